pyjamask_core: RTL and testbench
================================

Name: pyjamask_core

Overview:
- Parametrised successor to the fixed 96-bit byte-serial Pyjamask encryptor.
- Supports Pyjamask-96 and Pyjamask-128 by parameter and a configurable number of rounds per clock.
- The master key is loaded separately and retained, so successive blocks reuse it without reloading.
- Byte-serial valid/ready streams on key, plaintext and ciphertext; sits between the byte-wide host interface and the AEAD mode logic.

Parameters:
- BLOCK_BITS, 96: block width; only 96 (3 rows) or 128 (4 rows) are legal. Any other value is an elaboration error.
- ROUNDS_PER_CYCLE, 1: rounds evaluated per clock; must divide 14 (1, 2, 7, 14). Any other value is an elaboration error.
- NB_ROUNDS, 14: round count; fixed by the algorithm, not to be overridden.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- key_valid  in  1  key byte present
- key_byte  in  8  key byte, MSB-first, 16 bytes per key
- key_ready  out  1  key byte accepted when key_valid & key_ready
- in_valid  in  1  plaintext byte present
- in_byte  in  8  plaintext byte, MSB-first, BLOCK_BITS/8 bytes
- in_ready  out  1  plaintext byte accepted when in_valid & in_ready
- out_valid  out  1  ciphertext byte present
- out_byte  out  8  ciphertext byte, MSB-first
- out_ready  in  1  sink accepts byte
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - Clock is clk; reset is reset_n, asynchronous, active-low.
  - Reset clears the state register, master key, round key, byte counters and round counter to 0, and puts the FSM in IDLE.
  - Output reset values: out_valid=0, out_byte=0, busy=0, key_ready=1, in_ready=1.
  - Reset asserted mid-operation aborts everything; no partial output is produced.
- Key after reset: the key is all-zero until a key has been loaded.
- FSM states: IDLE, LOAD_KEY, LOAD_DATA, ROUND, FINAL, OUT.
- IDLE:
  - key_ready=1 and in_ready=!key_valid; the key has priority when both valids are high.
  - An accepted key byte goes to LOAD_KEY; an accepted data byte goes to LOAD_DATA.
- LOAD_KEY:
  - Each accepted byte shifts into master_key (new byte enters the LSBs) and increments kcnt.
  - When the 16th byte is accepted, the FSM returns to IDLE; kcnt wraps to 0.
  - in_ready=0 throughout.
- LOAD_DATA:
  - Same shifting into state, counted by dcnt.
  - On acceptance of byte BLOCK_BITS/8, round_key is set to master_key, rcnt=0, and the FSM goes to ROUND.
  - key_ready=0 throughout.
- ROUND: each edge applies ROUNDS_PER_CYCLE rounds. Per round r, in order:
  - AddRoundKey: row i ^= round_key row i, for i < rows.
  - SubBytes: each 32-bit column j takes bits (row0[31-j] as MSB … rowN-1[31-j]).
    - 96: S3 = {1,3,6,5,2,4,7,0}.
    - 128: S4 = {2,13,3,9,7,11,10,6,14,0,15,4,8,5,1,12}.
  - MixRows: row i = circulant-matrix multiply by first-column constant M0=a3861085, M1=63417021, M2=692cf280, M3=48a54813 (M3 is 128-bit only).
  - Key schedule advance:
    - MixColumns on 4-bit key columns.
    - k0 = MK(b881b9ca)·k0; k1 rotl 8; k2 rotl 15; k3 rotl 18.
    - Constants: k0 ^= 0x00000080^r; k1 ^= 0x00006a00; k2 ^= 0x003f0000; k3 ^= 0x24000000.
  - The 96-bit variant uses key rows 0..2 for AddRoundKey; the full 128-bit schedule always runs.
  - rcnt += ROUNDS_PER_CYCLE. When rcnt reaches 14, the FSM goes to FINAL.
- FINAL: state ^= round_key rows (K14), then the FSM goes to OUT.
- Latency: out_valid first rises 14/ROUNDS_PER_CYCLE + 1 edges after the edge that accepted the last input byte (15 for R=1).
- OUT:
  - out_byte is the MS byte of the output shift register; it is held stable while out_valid & !out_ready.
  - Each handshake shifts the register left by 8.
  - After the last byte is accepted, out_valid=0 next cycle, the FSM returns to IDLE and in_ready returns.
  - master_key is retained.
- No input is accepted in ROUND/FINAL/OUT (key_ready=in_ready=0).
- Round function authority: the team Pyjamask C golden model is authoritative for the round function and bit ordering.

Test Plan:
- Reset/idle: assert reset_n=0 mid-LOAD_DATA after 5 bytes, release, then apply 96'h0 plaintext -> out_valid=0, busy=0 during reset; after reset the block loads from byte 0 and produces the golden-model ciphertext for key=0, pt=0.
- KAT and latency (BLOCK_BITS=96, R=1): load key 000102…0f and pt 000102…0b -> output equals the golden-model ciphertext; out_valid rises exactly 15 edges after the last in handshake; 12 out bytes.
- Key reuse: load key once, encrypt two different blocks back-to-back -> both match the golden model; key_ready never needed in between.
- Backpressure: drive out_ready in a 1-0-0-1 pattern -> out_byte is stable while stalled; exactly 12 bytes; no byte duplicated or dropped.
- Arbitration: in IDLE, raise key_valid and in_valid in the same cycle -> key byte accepted, in_ready=0; data is accepted only after 16 key bytes.
- Parametric: BLOCK_BITS=128, R=2 -> out_valid rises 8 edges after the last of 16 input bytes; 16 output bytes match the golden-model Pyjamask-128 KAT.

Source files
------------

// File: rtl/pyjamask_if.sv
// Byte-serial key / plaintext / ciphertext streams of the Pyjamask core.
// master = host or AEAD side, slave = cipher core.
interface pyjamask_if;
    logic       key_valid;
    logic [7:0] key_byte;
    logic       key_ready;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       out_ready;

    modport master (
        output key_valid, key_byte,
        output in_valid, in_byte,
        output out_ready,
        input  key_ready, in_ready,
        input  out_valid, out_byte
    );

    modport slave (
        input  key_valid, key_byte,
        input  in_valid, in_byte,
        input  out_ready,
        output key_ready, in_ready,
        output out_valid, out_byte
    );
endinterface

// File: rtl/pyjamask_core.sv
// Pyjamask-96/128 block encryptor with retained master key and
// byte-serial streams; ROUNDS_PER_CYCLE rounds are unrolled per edge.
module pyjamask_core #(
    parameter int BLOCK_BITS       = 96,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NB_ROUNDS        = 14
) (
    input  logic      clk,
    input  logic      reset_n,
    pyjamask_if.slave bus,
    output logic      busy
);
    localparam int ROWS   = BLOCK_BITS / 32;
    localparam int NBYTES = BLOCK_BITS / 8;

    if (BLOCK_BITS != 96 && BLOCK_BITS != 128) begin : g_bad_block
        $error("pyjamask_core: BLOCK_BITS must be 96 or 128");
    end
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 7 || ROUNDS_PER_CYCLE == 14)) begin : g_bad_rpc
        $error("pyjamask_core: ROUNDS_PER_CYCLE must divide 14");
    end
    if (NB_ROUNDS != 14) begin : g_bad_nr
        $error("pyjamask_core: NB_ROUNDS is fixed at 14");
    end

    localparam logic [2:0] S3 [8] = '{
        3'd1, 3'd3, 3'd6, 3'd5, 3'd2, 3'd4, 3'd7, 3'd0
    };
    localparam logic [3:0] S4 [16] = '{
        4'd2,  4'd13, 4'd3,  4'd9,  4'd7,  4'd11, 4'd10, 4'd6,
        4'd14, 4'd0,  4'd15, 4'd4,  4'd8,  4'd5,  4'd1,  4'd12
    };
    localparam logic [31:0] MR [4] = '{
        32'ha3861085, 32'h63417021, 32'h692cf280, 32'h48a54813
    };
    localparam logic [31:0] MK = 32'hb881b9ca;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_LOAD_DATA,
        S_ROUND,
        S_FINAL,
        S_OUT
    } fsm_t;

    fsm_t                  r_fsm;
    fsm_t                  w_fsm_nxt;
    logic [BLOCK_BITS-1:0] r_state;
    logic [BLOCK_BITS-1:0] w_state_rnd;
    logic [127:0]          r_mkey;
    logic [127:0]          r_rkey;
    logic [127:0]          w_rkey_rnd;
    logic [3:0]            r_kcnt;
    logic [3:0]            r_dcnt;
    logic [3:0]            r_rcnt;
    logic                  w_key_hs;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic                  w_dcnt_last;
    logic                  w_rnd_last;

    // Circulant product: bit i of v (LSB index) selects M rotated right by 31-i.
    function automatic logic [31:0] f_mat(
        input logic [31:0] m,
        input logic [31:0] v
    );
        logic [31:0] acc;
        logic [31:0] col;
        acc = '0;
        col = m;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) acc = acc ^ col;
            col = {col[0], col[31:1]};
        end
        return acc;
    endfunction

    assign w_key_hs    = bus.key_valid & bus.key_ready;
    assign w_in_hs     = bus.in_valid & bus.in_ready;
    assign w_out_hs    = bus.out_valid & bus.out_ready;
    assign w_dcnt_last = (r_dcnt == 4'(NBYTES - 1));
    assign w_rnd_last  = ((r_rcnt + 4'(ROUNDS_PER_CYCLE)) == 4'(NB_ROUNDS));

    assign bus.out_byte = (r_fsm == S_OUT) ?
                          r_state[BLOCK_BITS-1 -: 8] : 8'h00;

    always_comb begin : p_round
        logic [31:0] s [ROWS];
        logic [31:0] k [4];
        logic [31:0] t;
        logic [3:0]  x;
        logic [3:0]  y;
        logic [3:0]  rc;
        w_state_rnd = '0;
        w_rkey_rnd  = '0;
        t  = '0;
        x  = '0;
        y  = '0;
        rc = '0;
        for (int i = 0; i < ROWS; i++)
            s[i] = r_state[BLOCK_BITS-1-32*i -: 32];
        for (int i = 0; i < 4; i++)
            k[i] = r_rkey[127-32*i -: 32];
        for (int n = 0; n < ROUNDS_PER_CYCLE; n++) begin
            rc = r_rcnt + 4'(n);
            for (int i = 0; i < ROWS; i++)
                s[i] = s[i] ^ k[i];
            // Bit-sliced S-box: row 0 supplies the MSB of each column.
            for (int b = 0; b < 32; b++) begin
                x = '0;
                for (int i = 0; i < ROWS; i++)
                    x = {x[2:0], s[i][b]};
                y = (ROWS == 3) ? {1'b0, S3[x[2:0]]} : S4[x];
                for (int i = 0; i < ROWS; i++)
                    s[i][b] = y[ROWS-1-i];
            end
            for (int i = 0; i < ROWS; i++)
                s[i] = f_mat(MR[i], s[i]);
            t = k[0] ^ k[1] ^ k[2] ^ k[3];
            for (int i = 0; i < 4; i++)
                k[i] = k[i] ^ t;
            k[0] = f_mat(MK, k[0]) ^ 32'h00000080 ^ {28'h0, rc};
            k[1] = {k[1][23:0], k[1][31:24]} ^ 32'h00006a00;
            k[2] = {k[2][16:0], k[2][31:17]} ^ 32'h003f0000;
            k[3] = {k[3][13:0], k[3][31:14]} ^ 32'h24000000;
        end
        for (int i = 0; i < ROWS; i++)
            w_state_rnd[BLOCK_BITS-1-32*i -: 32] = s[i];
        for (int i = 0; i < 4; i++)
            w_rkey_rnd[127-32*i -: 32] = k[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fsm <= S_IDLE;
        else          r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt     = r_fsm;
        bus.key_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        unique case (r_fsm)
            S_IDLE: begin
                busy          = 1'b0;
                bus.key_ready = 1'b1;
                bus.in_ready  = !bus.key_valid;
                if (bus.key_valid)
                    w_fsm_nxt = S_LOAD_KEY;
                else if (bus.in_valid)
                    w_fsm_nxt = S_LOAD_DATA;
            end
            S_LOAD_KEY: begin
                bus.key_ready = 1'b1;
                if (bus.key_valid && r_kcnt == 4'd15)
                    w_fsm_nxt = S_IDLE;
            end
            S_LOAD_DATA: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && w_dcnt_last)
                    w_fsm_nxt = S_ROUND;
            end
            S_ROUND: begin
                if (w_rnd_last)
                    w_fsm_nxt = S_FINAL;
            end
            S_FINAL: begin
                w_fsm_nxt = S_OUT;
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && w_dcnt_last)
                    w_fsm_nxt = S_IDLE;
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= '0;
            r_mkey  <= '0;
            r_rkey  <= '0;
            r_kcnt  <= '0;
            r_dcnt  <= '0;
            r_rcnt  <= '0;
        end else begin
            unique case (r_fsm)
                S_IDLE, S_LOAD_KEY, S_LOAD_DATA: begin
                    if (w_key_hs) begin
                        r_mkey <= {r_mkey[119:0], bus.key_byte};
                        r_kcnt <= r_kcnt + 4'd1;
                    end
                    if (w_in_hs) begin
                        r_state <= {r_state[BLOCK_BITS-9:0], bus.in_byte};
                        if (w_dcnt_last) begin
                            r_dcnt <= '0;
                            r_rkey <= r_mkey;
                            r_rcnt <= '0;
                        end else begin
                            r_dcnt <= r_dcnt + 4'd1;
                        end
                    end
                end
                S_ROUND: begin
                    r_state <= w_state_rnd;
                    r_rkey  <= w_rkey_rnd;
                    r_rcnt  <= r_rcnt + 4'(ROUNDS_PER_CYCLE);
                end
                S_FINAL: begin
                    r_state <= r_state ^ r_rkey[127 -: BLOCK_BITS];
                end
                S_OUT: begin
                    if (w_out_hs) begin
                        r_state <= {r_state[BLOCK_BITS-9:0], 8'h00};
                        r_dcnt  <= w_dcnt_last ? 4'd0 : r_dcnt + 4'd1;
                    end
                end
                default: begin
                    r_dcnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pyjamask_core.sv
// Scoreboard bench: a 96-bit/R=1 and a 128-bit/R=2 core share clk and reset.
// Expected ciphertext comes from a behavioural Pyjamask model.
module tb_pyjamask_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a;
    logic busy_b;
    bit   bp_en = 1'b0;

    always #5 clk = ~clk;

    pyjamask_if if_a ();
    pyjamask_if if_b ();

    pyjamask_core #(.BLOCK_BITS(96), .ROUNDS_PER_CYCLE(1)) u_a (
        .clk(clk), .reset_n(rst_n), .bus(if_a), .busy(busy_a)
    );
    pyjamask_core #(.BLOCK_BITS(128), .ROUNDS_PER_CYCLE(2)) u_b (
        .clk(clk), .reset_n(rst_n), .bus(if_b), .busy(busy_b)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];
    bit         stall [2];
    logic [7:0] hold [2];
    int         got [2];

    localparam logic [2:0] T3 [8] = '{
        3'd1, 3'd3, 3'd6, 3'd5, 3'd2, 3'd4, 3'd7, 3'd0
    };
    localparam logic [3:0] T4 [16] = '{
        4'd2,  4'd13, 4'd3,  4'd9,  4'd7,  4'd11, 4'd10, 4'd6,
        4'd14, 4'd0,  4'd15, 4'd4,  4'd8,  4'd5,  4'd1,  4'd12
    };
    localparam logic [31:0] TM [4] = '{
        32'ha3861085, 32'h63417021, 32'h692cf280, 32'h48a54813
    };

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Row-times-vector form: result bit p (MSB-first) is the parity of
    // row p of the circulant matrix whose first column is m.
    function automatic logic [31:0] m_mul(input logic [31:0] m,
                                          input logic [31:0] v);
        logic [31:0] res;
        res = '0;
        for (int p = 0; p < 32; p++) begin
            logic acc;
            acc = 1'b0;
            for (int q = 0; q < 32; q++)
                acc = acc ^ (v[31-q] & m[31-((p-q+32)%32)]);
            res[31-p] = acc;
        end
        return res;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] pj_model(input logic [127:0] key,
                                              input logic [127:0] pt,
                                              input int rows);
        logic [31:0]  s [4];
        logic [31:0]  k [4];
        logic [31:0]  t;
        logic [3:0]   x;
        logic [3:0]   y;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) begin
            s[i] = '0;
            k[i] = key[127-32*i -: 32];
        end
        for (int i = 0; i < rows; i++) s[i] = pt[32*(rows-1-i) +: 32];
        for (int r = 0; r < 14; r++) begin
            for (int i = 0; i < rows; i++) s[i] = s[i] ^ k[i];
            for (int j = 0; j < 32; j++) begin
                x = '0;
                for (int i = 0; i < rows; i++) x[rows-1-i] = s[i][31-j];
                y = (rows == 3) ? {1'b0, T3[x[2:0]]} : T4[x];
                for (int i = 0; i < rows; i++) s[i][31-j] = y[rows-1-i];
            end
            for (int i = 0; i < rows; i++) s[i] = m_mul(TM[i], s[i]);
            t = k[0] ^ k[1] ^ k[2] ^ k[3];
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ t;
            k[0] = m_mul(32'hb881b9ca, k[0]) ^ 32'h80 ^ 32'(r);
            k[1] = rotl(k[1], 8) ^ 32'h00006a00;
            k[2] = rotl(k[2], 15) ^ 32'h003f0000;
            k[3] = rotl(k[3], 18) ^ 32'h24000000;
        end
        for (int i = 0; i < rows; i++) s[i] = s[i] ^ k[i];
        res = '0;
        for (int i = 0; i < rows; i++) res[32*(rows-1-i) +: 32] = s[i];
        return res;
    endfunction

    task automatic expect_ct(input bit s, input logic [127:0] key,
                             input logic [127:0] pt);
        logic [127:0] ct;
        int           nb;
        nb = s ? 16 : 12;
        ct = pj_model(key, pt, nb / 4);
        for (int i = 0; i < nb; i++) begin
            if (s) exp_b.push_back(ct[8*(nb-1-i) +: 8]);
            else   exp_a.push_back(ct[8*(nb-1-i) +: 8]);
        end
    endtask

    function automatic bit rdy(input bit s, input bit is_key);
        if (s) return is_key ? if_b.key_ready : if_b.in_ready;
        return is_key ? if_a.key_ready : if_a.in_ready;
    endfunction

    task automatic put(input bit s, input bit is_key, input bit v,
                       input logic [7:0] b);
        if (s && is_key)  begin if_b.key_valid = v; if_b.key_byte = b; end
        if (s && !is_key) begin if_b.in_valid = v;  if_b.in_byte = b;  end
        if (!s && is_key)  begin if_a.key_valid = v; if_a.key_byte = b; end
        if (!s && !is_key) begin if_a.in_valid = v;  if_a.in_byte = b;  end
    endtask

    // Called at posedge+1; returns at posedge+1 after the last handshake.
    task automatic send(input bit s, input bit is_key,
                        input logic [127:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bit ok;
            int w;
            put(s, is_key, 1'b1, d[8*(n-1-i) +: 8]);
            ok = 1'b0;
            w = 0;
            while (!ok && w < 200) begin
                @(negedge clk);
                ok = rdy(s, is_key);
                @(posedge clk);
                #1;
                w++;
            end
            if (!ok) begin
                n_vec++;
                n_err++;
                $display("FAIL send byte %0d: got no ready, required ready", i);
            end
        end
        put(s, is_key, 1'b0, 8'h00);
    endtask

    task automatic lat(input bit s, input int req, input string name);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = s ? if_b.out_valid : if_a.out_valid;
        end
        check(name, 32'(n), 32'(req));
    endtask

    task automatic drain(input bit s, input int base, input int nb,
                         input string name);
        int w;
        w = 0;
        while (((s ? exp_b.size() : exp_a.size()) != 0 ||
                (s ? busy_b : busy_a)) && w < 600) begin
            @(negedge clk);
            w++;
        end
        check({name, " left"}, 32'(s ? exp_b.size() : exp_a.size()), 0);
        check({name, " count"}, 32'(got[s] - base), 32'(nb));
        check({name, " valid low"}, {31'h0, s ? if_b.out_valid : if_a.out_valid}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic mon(input bit s);
        logic       v;
        logic       r;
        logic [7:0] b;
        v = s ? if_b.out_valid : if_a.out_valid;
        r = s ? if_b.out_ready : if_a.out_ready;
        b = s ? if_b.out_byte : if_a.out_byte;
        if (!rst_n || !v) begin
            stall[s] = 1'b0;
            return;
        end
        if (stall[s]) check(s ? "B stall hold" : "A stall hold", {24'h0, b}, {24'h0, hold[s]});
        if (r) begin
            stall[s] = 1'b0;
            got[s]++;
            if ((s ? exp_b.size() : exp_a.size()) == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s extra byte: got %0h, required none", s ? "B" : "A", b);
            end else if (s) begin
                check("B out byte", {24'h0, b}, {24'h0, exp_b.pop_front()});
            end else begin
                check("A out byte", {24'h0, b}, {24'h0, exp_a.pop_front()});
            end
        end else begin
            stall[s] = 1'b1;
            hold[s] = b;
        end
    endtask

    initial forever begin
        @(negedge clk);
        mon(1'b0);
        mon(1'b1);
    end

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            if_a.out_ready = bp_en ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] k1;
        logic [127:0] k2;
        int           base;
        k1 = 128'h000102030405060708090a0b0c0d0e0f;
        k2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        got[0] = 0;
        got[1] = 0;
        put(0, 1, 0, 0); put(0, 0, 0, 0);
        put(1, 1, 0, 0); put(1, 0, 0, 0);
        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst out_valid", {31'h0, if_a.out_valid}, 0);
        check("rst out_byte", {24'h0, if_a.out_byte}, 0);
        check("rst busy", {31'h0, busy_a}, 0);
        check("rst key_ready", {31'h0, if_a.key_ready}, 1);
        check("rst in_ready", {31'h0, if_a.in_ready}, 1);
        check("rst busy B", {31'h0, busy_b}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(0, 0, 128'h1122334455, 5);
        check("busy in load", {31'h0, busy_a}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort out_valid", {31'h0, if_a.out_valid}, 0);
        check("abort busy", {31'h0, busy_a}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        base = got[0];
        expect_ct(0, '0, '0);
        send(0, 0, '0, 12);
        lat(0, 15, "zero-key latency");
        drain(0, base, 12, "zero block");

        send(0, 1, k1, 16);
        base = got[0];
        expect_ct(0, k1, 128'h000102030405060708090a0b);
        send(0, 0, 128'h000102030405060708090a0b, 12);
        lat(0, 15, "KAT latency");
        drain(0, base, 12, "KAT block");

        base = got[0];
        expect_ct(0, k1, 128'hffeeddccbbaa998877665544);
        expect_ct(0, k1, 128'h0123456789abcdef02468ace);
        send(0, 0, 128'hffeeddccbbaa998877665544, 12);
        send(0, 0, 128'h0123456789abcdef02468ace, 12);
        drain(0, base, 24, "key reuse");

        bp_en = 1'b1;
        base = got[0];
        expect_ct(0, k1, 128'h13579bdf2468ace0deadbeef);
        send(0, 0, 128'h13579bdf2468ace0deadbeef, 12);
        drain(0, base, 12, "backpressure");
        bp_en = 1'b0;

        put(0, 0, 1, 8'hca);
        put(0, 1, 1, k2[127:120]);
        @(negedge clk);
        check("arb in_ready", {31'h0, if_a.in_ready}, 0);
        check("arb key_ready", {31'h0, if_a.key_ready}, 1);
        @(posedge clk);
        #1;
        send(0, 1, k2, 15);
        base = got[0];
        expect_ct(0, k2, 128'hcafef00d5566778899aabbcc);
        send(0, 0, 128'hcafef00d5566778899aabbcc, 12);
        drain(0, base, 12, "arbitration");

        send(1, 1, k1, 16);
        base = got[1];
        expect_ct(1, k1, 128'h000102030405060708090a0b0c0d0e0f);
        send(1, 0, 128'h000102030405060708090a0b0c0d0e0f, 16);
        lat(1, 8, "128 latency");
        drain(1, base, 16, "128 block");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
